// File: rtl/mem_access_if.sv
// Request/response and data-memory signal bundle for the load/store sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface mem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [6:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   // Handshake: a request transfers on the rising edge where req_valid & req_ready;
   // the requester holds req_* stable until then. resp_valid is a single-cycle
   // pulse with no backpressure.
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a 128 x 32 synchronous data memory: word stores write
// directly, sub-word stores read-modify-write, loads extract and extend a lane.
module mem_access_unit (
   input  logic         clk,
   input  logic         rst_n,
   mem_access_if.slave  bus,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      EXT  = 3'd2,
      WR   = 3'd3,
      WRM  = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t      state;
   logic        l_we;
   logic [1:0]  l_size;
   logic        l_uns;
   logic [1:0]  l_off;
   logic [31:0] l_wdata;
   logic        req_bad;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ext_data;
   logic [31:0] merged;

   assign req_bad = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

   assign bus.req_ready = (state == IDLE);
   assign bus.mem_we    = (state == WR) || (state == WRM);
   assign dbg_state     = state;

   // Lane select/extend for loads and lane merge for read-modify-write stores.
   always_comb begin
      lane_b   = bus.mem_rdata[{l_off, 3'b000} +: 8];
      lane_h   = l_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      ext_data = bus.mem_rdata;
      merged   = bus.mem_rdata;
      case (l_size)
         2'b00: begin
            ext_data = l_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            merged[{l_off, 3'b000} +: 8] = l_wdata[7:0];
         end
         2'b01: begin
            ext_data = l_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            if (l_off[1]) merged[31:16] = l_wdata[15:0];
            else          merged[15:0]  = l_wdata[15:0];
         end
         default: begin
            ext_data = bus.mem_rdata;
            merged   = l_wdata;
         end
      endcase
   end

   always_comb begin
      bus.mem_wdata = 32'h0;
      if (state == WR)       bus.mem_wdata = l_wdata;
      else if (state == WRM) bus.mem_wdata = merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         l_we           <= 1'b0;
         l_size         <= 2'b00;
         l_uns          <= 1'b0;
         l_off          <= 2'b00;
         l_wdata        <= 32'h0;
         bus.mem_addr   <= 7'h0;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= 32'h0;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  l_we         <= bus.req_we;
                  l_size       <= bus.req_size;
                  l_uns        <= bus.req_unsigned;
                  l_off        <= bus.req_addr[1:0];
                  l_wdata      <= bus.req_wdata;
                  bus.mem_addr <= bus.req_addr[8:2];
                  if (req_bad)                                 state <= ERR;
                  else if (bus.req_we && bus.req_size == 2'b10) state <= WR;
                  else                                         state <= RD;
               end
            end
            RD:  state <= l_we ? WRM : EXT;
            EXT: begin
               bus.resp_rdata <= ext_data;
               bus.resp_valid <= 1'b1;
               state          <= IDLE;
            end
            WR, WRM: begin
               bus.resp_valid <= 1'b1;
               state          <= IDLE;
            end
            ERR: begin
               bus.resp_valid <= 1'b1;
               bus.resp_err   <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors against a
// behavioural 128-word memory, plus reset-during-write and back-to-back sequences.
module tb_mem_access_unit;

   logic       clk;
   logic       rst_n;
   logic [2:0] dbg_state;
   int         total;
   int         bad;
   int         we_cnt;

   mem_access_if bus ();

   mem_access_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [31:0] mem [128];
   logic [31:0] mem_rd;
   logic        pl_en;
   logic [6:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd <= mem[bus.mem_addr];
      if (pl_en)      mem[pl_addr] <= pl_data;
   end
   assign bus.mem_rdata = mem_rd;

   always @(posedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [6:0] a, input logic [31:0] d);
      pl_addr = a; pl_data = d; pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Call at a negedge; returns at the negedge where resp_valid is seen.
   // lat counts negedges after the acceptance edge up to the response.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [8:0] addr, input logic [31:0] wdata,
                         output int lat, output logic err, output logic [31:0] rdata);
      logic acc;
      acc = 1'b0;
      lat = 0;
      bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) begin
         acc = bus.req_ready;
         @(posedge clk);
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         lat++;
         if (bus.resp_valid) break;
      end
      err   = bus.resp_err;
      rdata = bus.resp_rdata;
      if (!bus.resp_valid) begin
         chk("resp_timeout", 32'd0, 32'd1);
         lat = -1;
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int          lat;
      int          we0;
      logic        err;
      logic [31:0] rdata;
      logic        acc;

      total = 0; bad = 0; we_cnt = 0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

      //             we  size   uns addr     wdata          err rdata          lat
      vecs[0]  = '{1'b1, 2'b00, 1'b0, 9'h012, 32'h000000AA, 1'b0, 32'hDEADBEEF, 3};
      vecs[1]  = '{1'b0, 2'b00, 1'b0, 9'h012, 32'h0,        1'b0, 32'hFFFFFFAA, 3};
      vecs[2]  = '{1'b0, 2'b00, 1'b1, 9'h012, 32'h0,        1'b0, 32'h000000AA, 3};
      vecs[3]  = '{1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        1'b0, 32'h000011AA, 3};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 9'h010, 32'h0,        1'b0, 32'h00003344, 3};
      vecs[5]  = '{1'b1, 2'b01, 1'b0, 9'h022, 32'h12348001, 1'b0, 32'h00003344, 3};
      vecs[6]  = '{1'b0, 2'b01, 1'b0, 9'h022, 32'h0,        1'b0, 32'hFFFF8001, 3};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 9'h023, 32'h0,        1'b0, 32'hFFFFFF80, 3};
      vecs[8]  = '{1'b0, 2'b00, 1'b1, 9'h021, 32'h0,        1'b0, 32'h00000000, 3};
      vecs[9]  = '{1'b1, 2'b01, 1'b0, 9'h011, 32'h0000BEEF, 1'b1, 32'h00000000, 2};
      vecs[10] = '{1'b0, 2'b10, 1'b0, 9'h006, 32'h0,        1'b1, 32'h00000000, 2};
      vecs[11] = '{1'b0, 2'b11, 1'b0, 9'h000, 32'h0,        1'b1, 32'h00000000, 2};
      vecs[12] = '{1'b1, 2'b00, 1'b0, 9'h013, 32'hFFFFFF55, 1'b0, 32'h00000000, 3};
      vecs[13] = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        1'b0, 32'h55AA3344, 3};
      vecs[14] = '{1'b0, 2'b10, 1'b0, 9'h020, 32'h0,        1'b0, 32'h80010000, 3};
      vecs[15] = '{1'b1, 2'b10, 1'b0, 9'h01E, 32'h12345678, 1'b1, 32'h80010000, 2};

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready",  {31'h0, bus.req_ready},  32'd1);
      chk("rst_valid",  {31'h0, bus.resp_valid}, 32'd0);
      chk("rst_err",    {31'h0, bus.resp_err},   32'd0);
      chk("rst_rdata",  bus.resp_rdata,          32'h0);
      chk("rst_maddr",  {25'h0, bus.mem_addr},   32'h0);
      chk("rst_mwe",    {31'h0, bus.mem_we},     32'd0);
      chk("rst_mwdata", bus.mem_wdata,           32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Word store then word load
      do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, lat, err, rdata);
      chk("wst_lat", lat, 2);
      chk("wst_err", {31'h0, err}, 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, lat, err, rdata);
      chk("wld_lat", lat, 3);
      chk("wld_err", {31'h0, err}, 32'd0);
      chk("wld_rdata", rdata, 32'hDEADBEEF);

      preload(7'd4, 32'h11223344);
      preload(7'd5, 32'hCAFEF00D);
      preload(7'd8, 32'h00000000);
      @(negedge clk);

      foreach (vecs[i]) begin
         we0 = we_cnt;
         do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                lat, err, rdata);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         if (vecs[i].exp_err)
            chk($sformatf("v%0d_no_write", i), we_cnt - we0, 0);
         if (i == 0) begin
            chk("bst_word4", mem[4], 32'h11AA3344);
            chk("bst_word5", mem[5], 32'hCAFEF00D);
         end
      end
      chk("end_word4", mem[4], 32'h55AA3344);
      chk("end_word5", mem[5], 32'hCAFEF00D);
      chk("end_word8", mem[8], 32'h80010000);

      // Reset in the WRM cycle of a byte store
      preload(7'd10, 32'h01020304);
      bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
      bus.req_addr = 9'h028; bus.req_wdata = 32'h000000EE; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("wrm_state", {29'h0, dbg_state}, 32'd4);
      chk("wrm_we",    {31'h0, bus.mem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rrst_mwe",    {31'h0, bus.mem_we},     32'd0);
      chk("rrst_mwdata", bus.mem_wdata,           32'h0);
      chk("rrst_maddr",  {25'h0, bus.mem_addr},   32'h0);
      chk("rrst_rdata",  bus.resp_rdata,          32'h0);
      chk("rrst_err",    {31'h0, bus.resp_err},   32'd0);
      chk("rrst_ready",  {31'h0, bus.req_ready},  32'd1);
      @(negedge clk);
      chk("rrst_valid",  {31'h0, bus.resp_valid}, 32'd0);
      chk("rrst_word10", mem[10], 32'h01020304);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rrst_valid2", {31'h0, bus.resp_valid}, 32'd0);

      // Back-to-back word store then load with req_valid held high
      bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = 9'h030; bus.req_wdata = 32'h0BADF00D; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_wdata = 32'h0;
      @(negedge clk);
      chk("b2b_st_valid", {31'h0, bus.resp_valid}, 32'd1);
      chk("b2b_st_ready", {31'h0, bus.req_ready},  32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("b2b_ld_accepted", {29'h0, dbg_state}, 32'd1);
      acc = 1'b0;
      lat = 1;
      for (int i = 0; i < 10 && !acc; i++) begin
         @(negedge clk);
         lat++;
         acc = bus.resp_valid;
      end
      chk("b2b_ld_lat", lat, 3);
      chk("b2b_ld_rdata", bus.resp_rdata, 32'h0BADF00D);
      chk("b2b_word12", mem[12], 32'h0BADF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
